// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and helpers for the data-memory responder slice.
//   state_t      : responder FSM states (IDLE accepts, BUSY waits, RESP presents)
//   WORD_W       : data word width in bits
//   STRB_W       : number of byte enables per word
//   expand_strb  : turns a per-byte enable vector into a per-bit mask
package dmem_pkg;

  localparam int WORD_W = 64;
  localparam int STRB_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  // Each enable bit i covers bits [8i+7:8i] of the word.
  function automatic logic [WORD_W-1:0] expand_strb(input logic [STRB_W-1:0] strb);
    logic [WORD_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank
// DEPTH_WORDS x 64-bit storage with one read port and one byte-masked write
// port sharing a single index. The read port returns the merged (post-write)
// word when a write is enabled in the same cycle.
// Ports:
//   clock  : write clock
//   we     : write enable (byte lanes selected by wstrb)
//   idx    : word index for both read and write
//   wstrb  : byte enables
//   wdata  : lane-aligned write data
//   rdata  : word at idx (new data when we=1)
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] merged;

  assign mask   = expand_strb(wstrb);
  assign merged = (mem[idx] & ~mask) | (wdata & mask);

  // Bypass the write so a same-cycle read sees the committed value.
  assign rdata = we ? merged : mem[idx];

  // Storage is intentionally never reset; contents survive responder reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= merged;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Slave end of the LSU load/store interface. Accepts one request at a time,
// performs a byte-masked 64-bit store or a 64-bit load after LATENCY cycles,
// and holds the response until the requester takes it.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   io_req_valid/ready  : request handshake (ready only in IDLE)
//   io_req_wen/ren      : store / load command bits
//   io_req_wstrb        : store byte enables
//   io_req_addr         : byte address (bits [2:0] ignored)
//   io_req_wdata        : store data
//   io_resp_valid/ready : response handshake (valid only in RESP)
//   io_resp_rdata       : load data, zero for stores, errors and no-ops
//   io_resp_err         : out-of-range address or wen and ren both set
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_wen,
  input  logic              io_req_ren,
  input  logic [STRB_W-1:0] io_req_wstrb,
  input  logic [63:0]       io_req_addr,
  input  logic [WORD_W-1:0] io_req_wdata,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [WORD_W-1:0] io_resp_rdata,
  output logic              io_resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t            state;
  logic [CNT_W-1:0]  count;

  logic              lat_wen;
  logic              lat_ren;
  logic              lat_ok;
  logic [STRB_W-1:0] lat_strb;
  logic [IDX_W-1:0]  lat_idx;
  logic [WORD_W-1:0] lat_wdata;

  logic [63:0]       req_off;
  logic              req_ok;
  logic [IDX_W-1:0]  req_idx;

  logic              use_live;
  logic              c_wen;
  logic              c_ren;
  logic              c_ok;
  logic [STRB_W-1:0] c_strb;
  logic [IDX_W-1:0]  c_idx;
  logic [WORD_W-1:0] c_wdata;
  logic              c_err;
  logic              commit;
  logic              bank_we;
  logic [WORD_W-1:0] bank_rdata;
  logic [WORD_W-1:0] rdata_next;

  // Handshake outputs are pure state decodes, never paths from the inputs.
  assign io_req_ready  = (state == IDLE);
  assign io_resp_valid = (state == RESP);

  // Range check is done on the full 64-bit offset so addresses below the
  // base cannot wrap around into the valid window.
  assign req_off = io_req_addr - BASE_ADDR;
  assign req_ok  = (io_req_addr >= BASE_ADDR) && ((req_off >> 3) < 64'(DEPTH_WORDS));
  assign req_idx = req_off[IDX_W+2:3];

  // With LATENCY=1 the commit happens on the accept edge itself, so the
  // live request fields feed the commit logic; otherwise the latched copy.
  assign use_live = (state == IDLE);
  assign c_wen    = use_live ? io_req_wen   : lat_wen;
  assign c_ren    = use_live ? io_req_ren   : lat_ren;
  assign c_ok     = use_live ? req_ok       : lat_ok;
  assign c_strb   = use_live ? io_req_wstrb : lat_strb;
  assign c_idx    = use_live ? req_idx      : lat_idx;
  assign c_wdata  = use_live ? io_req_wdata : lat_wdata;

  // An out-of-range address only matters when a command is actually issued;
  // a request with neither wen nor ren is a harmless no-op.
  assign c_err = c_ok ? (c_wen & c_ren) : (c_wen | c_ren);

  // Commit is the edge that moves the FSM into RESP; a reset on that edge
  // cancels the write.
  assign commit = !reset &&
                  (((state == IDLE) && io_req_valid && (LATENCY == 1)) ||
                   ((state == BUSY) && (count == CNT_W'(1))));

  assign bank_we    = commit && c_wen && !c_ren && c_ok;
  assign rdata_next = (c_ren && !c_wen && c_ok) ? bank_rdata : '0;

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clock (clock),
    .we    (bank_we),
    .idx   (c_idx),
    .wstrb (c_strb),
    .wdata (c_wdata),
    .rdata (bank_rdata)
  );

  // Request FSM: latch on accept, count down the access latency, present
  // the registered response and hold it until the requester takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      io_resp_rdata <= '0;
      io_resp_err   <= 1'b0;
      lat_wen       <= 1'b0;
      lat_ren       <= 1'b0;
      lat_ok        <= 1'b0;
      lat_strb      <= '0;
      lat_idx       <= '0;
      lat_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_req_valid) begin
            lat_wen   <= io_req_wen;
            lat_ren   <= io_req_ren;
            lat_ok    <= req_ok;
            lat_strb  <= io_req_wstrb;
            lat_idx   <= req_idx;
            lat_wdata <= io_req_wdata;
            if (LATENCY == 1) begin
              state         <= RESP;
              io_resp_rdata <= rdata_next;
              io_resp_err   <= c_err;
            end else begin
              state <= BUSY;
              count <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (count == CNT_W'(1)) begin
            state         <= RESP;
            count         <= '0;
            io_resp_rdata <= rdata_next;
            io_resp_err   <= c_err;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        RESP: begin
          if (io_resp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Scoreboard bench for dmem_responder. Two instances are exercised: unit 0
// with LATENCY=2 and unit 1 with LATENCY=1. Each issued request pushes its
// hand-computed response onto a per-unit queue; an independent monitor pops
// and compares whenever a response is handed over.
module tb_dmem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic        req_ren    [2];
  logic [7:0]  req_wstrb  [2];
  logic [63:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_rdata [2];
  logic        resp_err   [2];

  int   cyc;
  int   n_pass;
  int   n_total;
  int   issued [2];
  int   done   [2];
  exp_t q0 [$];
  exp_t q1 [$];

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (BASE),
    .LATENCY     (2)
  ) dut_lat2 (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (req_valid[0]),
    .io_req_ready  (req_ready[0]),
    .io_req_wen    (req_wen[0]),
    .io_req_ren    (req_ren[0]),
    .io_req_wstrb  (req_wstrb[0]),
    .io_req_addr   (req_addr[0]),
    .io_req_wdata  (req_wdata[0]),
    .io_resp_valid (resp_valid[0]),
    .io_resp_ready (resp_ready[0]),
    .io_resp_rdata (resp_rdata[0]),
    .io_resp_err   (resp_err[0])
  );

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (BASE),
    .LATENCY     (1)
  ) dut_lat1 (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (req_valid[1]),
    .io_req_ready  (req_ready[1]),
    .io_req_wen    (req_wen[1]),
    .io_req_ren    (req_ren[1]),
    .io_req_wstrb  (req_wstrb[1]),
    .io_req_addr   (req_addr[1]),
    .io_req_wdata  (req_wdata[1]),
    .io_resp_valid (resp_valid[1]),
    .io_resp_ready (resp_ready[1]),
    .io_resp_rdata (resp_rdata[1]),
    .io_resp_err   (resp_err[1])
  );

  // Free-running clock and a cycle counter used to time responses.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string name, input int u,
                             input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s (unit %0d): got %h, expected %h", name, u, act, req);
    end
  endtask

  task automatic noteTimeout(input string name, input int u);
    n_total++;
    $display("[TB] FAIL %s (unit %0d): got timeout, expected handshake", name, u);
  endtask

  task automatic checkResetOutputs(input int u);
    checkOutput("rst_req_ready", u, 64'(req_ready[u]), 64'd1);
    checkOutput("rst_resp_valid", u, 64'(resp_valid[u]), 64'd0);
    checkOutput("rst_resp_rdata", u, resp_rdata[u], 64'd0);
    checkOutput("rst_resp_err", u, 64'(resp_err[u]), 64'd0);
  endtask

  // Issues one request, records the expected response and waits until the
  // monitor has consumed it. hold>0 keeps resp_ready low for that many
  // cycles once the response appears, checking it stays put.
  task automatic applyStimulus(input int u, input logic wen, input logic ren,
                               input logic [7:0] strb, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [63:0] exp_rdata,
                               input logic exp_err, input int hold);
    exp_t e;
    int   t;
    @(posedge clock);
    #1;
    req_wen[u]    = wen;
    req_ren[u]    = ren;
    req_wstrb[u]  = strb;
    req_addr[u]   = addr;
    req_wdata[u]  = wdata;
    req_valid[u]  = 1'b1;
    resp_ready[u] = (hold == 0);
    @(negedge clock);
    t = 0;
    while (req_ready[u] !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      noteTimeout("req_accept", u);
      req_valid[u] = 1'b0;
      return;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.acc   = cyc;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
    issued[u]++;
    @(posedge clock);
    #1;
    req_valid[u] = 1'b0;
    if (hold > 0) begin
      t = 0;
      @(negedge clock);
      while (resp_valid[u] !== 1'b1 && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (t >= 50) begin
        noteTimeout("bp_resp_valid", u);
      end
      for (int i = 0; i < hold; i++) begin
        if (i > 0) @(negedge clock);
        checkOutput("bp_resp_valid", u, 64'(resp_valid[u]), 64'd1);
        checkOutput("bp_req_ready", u, 64'(req_ready[u]), 64'd0);
        checkOutput("bp_rdata", u, resp_rdata[u], exp_rdata);
        checkOutput("bp_err", u, 64'(resp_err[u]), 64'(exp_err));
      end
      @(posedge clock);
      #1;
      resp_ready[u] = 1'b1;
    end
    t = 0;
    while (done[u] != issued[u] && t < 50) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (done[u] != issued[u]) begin
      noteTimeout("resp_consume", u);
    end
    if (hold > 0) begin
      @(negedge clock);
      checkOutput("post_bp_req_ready", u, 64'(req_ready[u]), 64'd1);
      checkOutput("post_bp_resp_valid", u, 64'(resp_valid[u]), 64'd0);
    end
  endtask

  // Monitor: on every handed-over response, pop the oldest expectation and
  // compare data, error flag and accept-to-valid latency.
  initial begin
    int   first_cyc  [2];
    logic prev_valid [2];
    exp_t e;
    bit   have;
    for (int u = 0; u < 2; u++) begin
      first_cyc[u]  = 0;
      prev_valid[u] = 1'b0;
    end
    forever begin
      @(negedge clock);
      for (int u = 0; u < 2; u++) begin
        if (resp_valid[u] === 1'b1 && prev_valid[u] !== 1'b1) begin
          first_cyc[u] = cyc;
        end
        prev_valid[u] = resp_valid[u];
        if (resp_valid[u] === 1'b1 && resp_ready[u] === 1'b1) begin
          have = 1'b0;
          if (u == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
          end else if (u == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
          end
          if (!have) begin
            n_total++;
            $display("[TB] FAIL unexpected_resp (unit %0d): got response, expected none", u);
          end else begin
            checkOutput("rdata", u, resp_rdata[u], e.rdata);
            checkOutput("err", u, 64'(resp_err[u]), 64'(e.err));
            checkOutput("latency", u, 64'(first_cyc[u] - e.acc), 64'(lat_of(u)));
          end
          done[u]++;
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u]  = 1'b0;
      req_wen[u]    = 1'b0;
      req_ren[u]    = 1'b0;
      req_wstrb[u]  = 8'h00;
      req_addr[u]   = 64'd0;
      req_wdata[u]  = 64'd0;
      resp_ready[u] = 1'b1;
      issued[u]     = 0;
      done[u]       = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkResetOutputs(0);
    checkResetOutputs(1);

    // Unit 0, LATENCY=2: full store, load back, masked store, load back.
    applyStimulus(0, 1, 0, 8'hFF, 64'h8000_0010, 64'h1122334455667788, 64'd0, 0, 0);
    applyStimulus(0, 0, 1, 8'h00, 64'h8000_0010, 64'd0, 64'h1122334455667788, 0, 0);
    applyStimulus(0, 1, 0, 8'h0F, 64'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 64'd0, 0, 0);
    applyStimulus(0, 0, 1, 8'h00, 64'h8000_0010, 64'd0, 64'h11223344AAAAAAAA, 0, 0);

    // Range boundaries: preload last word, then probe below base and one past end.
    applyStimulus(0, 1, 0, 8'hFF, 64'h8000_1FF8, 64'h5555555555555555, 64'd0, 0, 0);
    applyStimulus(0, 0, 1, 8'h00, 64'h7FFF_FFF8, 64'd0, 64'd0, 1, 0);
    applyStimulus(0, 1, 0, 8'hFF, 64'h8000_2000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 0);
    applyStimulus(0, 0, 1, 8'h00, 64'h8000_1FF8, 64'd0, 64'h5555555555555555, 0, 0);

    // Illegal and no-op commands must leave memory alone.
    applyStimulus(0, 1, 1, 8'hFF, 64'h8000_0010, 64'h0, 64'd0, 1, 0);
    applyStimulus(0, 0, 0, 8'hFF, 64'h8000_0010, 64'h0, 64'd0, 0, 0);
    applyStimulus(0, 0, 1, 8'h00, 64'h8000_0010, 64'd0, 64'h11223344AAAAAAAA, 0, 0);

    // Preload word 3, then a load held under response backpressure.
    applyStimulus(0, 1, 0, 8'hFF, 64'h8000_0018, 64'h0123456789ABCDEF, 64'd0, 0, 0);
    applyStimulus(0, 0, 1, 8'h00, 64'h8000_0010, 64'd0, 64'h11223344AAAAAAAA, 0, 5);

    // Reset while a store to word 3 sits in BUSY: it must be discarded.
    @(posedge clock);
    #1;
    req_wen[0]    = 1'b1;
    req_ren[0]    = 1'b0;
    req_wstrb[0]  = 8'hFF;
    req_addr[0]   = 64'h8000_0018;
    req_wdata[0]  = 64'h000000000000DEAD;
    req_valid[0]  = 1'b1;
    resp_ready[0] = 1'b1;
    @(negedge clock);
    checkOutput("pre_reset_req_ready", 0, 64'(req_ready[0]), 64'd1);
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    reset        = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkResetOutputs(0);
    applyStimulus(0, 0, 1, 8'h00, 64'h8000_0018, 64'd0, 64'h0123456789ABCDEF, 0, 0);

    // Unit 1, LATENCY=1.
    applyStimulus(1, 1, 0, 8'hFF, 64'h8000_0008, 64'hCAFEBABE01020304, 64'd0, 0, 0);
    applyStimulus(1, 0, 1, 8'h00, 64'h8000_0008, 64'd0, 64'hCAFEBABE01020304, 0, 0);
    applyStimulus(1, 1, 0, 8'h00, 64'h8000_0008, 64'hFFFFFFFFFFFFFFFF, 64'd0, 0, 0);
    applyStimulus(1, 0, 1, 8'h00, 64'h8000_0008, 64'd0, 64'hCAFEBABE01020304, 0, 0);
    applyStimulus(1, 1, 0, 8'hF0, 64'h8000_0008, 64'h99887766FFFFFFFF, 64'd0, 0, 0);
    applyStimulus(1, 0, 1, 8'h00, 64'h8000_0008, 64'd0, 64'h9988776601020304, 0, 0);
    applyStimulus(1, 1, 1, 8'hFF, 64'h8000_0008, 64'h0, 64'd0, 1, 0);
    applyStimulus(1, 0, 0, 8'h00, 64'h8000_0008, 64'h0, 64'd0, 0, 0);
    applyStimulus(1, 0, 1, 8'h00, 64'h8000_2000, 64'd0, 64'd0, 1, 0);
    applyStimulus(1, 0, 1, 8'h00, 64'h8000_0008, 64'd0, 64'h9988776601020304, 0, 3);

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
